// File: rtl/ms_uart_tx_sched.sv
// ---------------------------------------------------------------------------
// ms_uart_tx_sched
//
// APB master that brings up a single ms_uart_apb peripheral (PRESCALE, then
// CTRL) and afterwards shares the peripheral's TX FIFO between NREQ byte
// requesters. Requesters are granted round-robin. For every granted byte the
// sticky TX-full flag is cleared through ICR, one idle bus cycle is left so
// the flag can re-assert, RIS is read back, and the byte is written to DATA
// only once the flag reads clear.
//
// Ports
//   PCLK, PRESET         clock, asynchronous active-high reset
//   req_valid[NREQ]      per-requester byte valid (held until req_ready)
//   req_data[8*NREQ]     byte of requester i in bits [8i+7:8i]
//   req_ready[NREQ]      one-hot pulse in the cycle the DATA write completes
//   init_done            high once bring-up has finished, until reset
//   PSEL/PENABLE/PWRITE  APB master controls
//   PADDR, PWDATA        APB address / write data (upper 16 address bits 0)
//   PRDATA, PREADY       APB read data / ready (wait states honoured)
// ---------------------------------------------------------------------------
module ms_uart_tx_sched #(
    parameter int unsigned NREQ     = 4,
    parameter logic [15:0] PRESCALE = 16'd0,
    parameter logic [31:0] CTRL_VAL = 32'h7
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              init_done,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [31:0]       PADDR,
    output logic [31:0]       PWDATA,
    input  logic [31:0]       PRDATA,
    input  logic              PREADY
);

    localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [15:0] ADDR_DATA     = 16'h0000;
    localparam logic [15:0] ADDR_PRESCALE = 16'h0004;
    localparam logic [15:0] ADDR_CTRL     = 16'h0100;
    localparam logic [15:0] ADDR_RIS      = 16'h0200;
    localparam logic [15:0] ADDR_ICR      = 16'h020C;

    typedef enum logic [2:0] {
        S_INIT_PS,
        S_INIT_CTRL,
        S_IDLE,
        S_CLR,
        S_GAP,
        S_POLL,
        S_WR
    } state_t;

    state_t          state_q, state_d;
    logic            access_q, access_d;       // 0: setup phase, 1: access phase
    logic            run_q;                    // low from reset until the first edge
    logic            init_done_q, init_done_d;
    logic [IDXW-1:0] ptr_q, ptr_d;             // last requester served
    logic [IDXW-1:0] grant_q, grant_d;
    logic [7:0]      byte_q, byte_d;

    // Only RIS[0] (sticky TX-full) is of interest in read data.
    logic unused_prdata;
    assign unused_prdata = ^PRDATA[31:1];

    // -----------------------------------------------------------------------
    // Requester byte lanes
    // -----------------------------------------------------------------------
    logic [7:0] req_byte [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_byte[i] = req_data[8*i +: 8];
        end
    end

    // -----------------------------------------------------------------------
    // Round-robin search: first valid index starting at ptr+1, wrapping.
    // ptr < NREQ, so ptr+k never exceeds 2*NREQ-1 and one wrap is enough.
    // -----------------------------------------------------------------------
    logic            gnt_any;
    logic [IDXW-1:0] gnt_idx;
    int unsigned     cand_sum;
    logic [IDXW-1:0] cand;

    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        cand_sum = 0;
        cand     = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand_sum = 32'(ptr_q) + k;
            if (cand_sum >= NREQ) begin
                cand_sum = cand_sum - NREQ;
            end
            cand = IDXW'(cand_sum);
            if (!gnt_any && req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= S_INIT_PS;
            access_q    <= 1'b0;
            run_q       <= 1'b0;
            init_done_q <= 1'b0;
            ptr_q       <= IDXW'(NREQ - 1);
            grant_q     <= '0;
        end else begin
            state_q     <= state_d;
            access_q    <= access_d;
            run_q       <= 1'b1;
            init_done_q <= init_done_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
        end
    end

    // The latched byte is pure data; it is always loaded before it is used.
    always_ff @(posedge PCLK) begin
        byte_q <= byte_d;
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        access_d    = access_q;
        init_done_d = init_done_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        byte_d      = byte_q;

        // The cycle after reset release is spent with the bus quiet; the
        // first transfer's setup phase starts on the first edge.
        if (run_q) begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_any) begin
                        grant_d = gnt_idx;
                        byte_d  = req_byte[gnt_idx];
                        state_d = S_CLR;
                    end
                end

                // Bus idle for one cycle so RIS[0] can re-assert if the
                // FIFO is still full after the clear.
                S_GAP: begin
                    state_d = S_POLL;
                end

                default: begin
                    // Every other state is a single APB transfer.
                    if (!access_q) begin
                        access_d = 1'b1;
                    end else if (PREADY) begin
                        access_d = 1'b0;
                        case (state_q)
                            S_INIT_PS: begin
                                state_d = S_INIT_CTRL;
                            end
                            S_INIT_CTRL: begin
                                state_d     = S_IDLE;
                                init_done_d = 1'b1;
                            end
                            S_CLR: begin
                                state_d = S_GAP;
                            end
                            S_POLL: begin
                                state_d = PRDATA[0] ? S_CLR : S_WR;
                            end
                            S_WR: begin
                                state_d = S_IDLE;
                                ptr_d   = grant_q;
                            end
                            default: begin
                                state_d = S_INIT_PS;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Bus and handshake outputs, decoded from the registered state so they
    // drop to zero the moment reset is asserted.
    // -----------------------------------------------------------------------
    always_comb begin
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        PWRITE    = 1'b0;
        PADDR     = 32'h0;
        PWDATA    = 32'h0;
        req_ready = '0;

        if (run_q) begin
            case (state_q)
                S_INIT_PS: begin
                    PSEL   = 1'b1;
                    PWRITE = 1'b1;
                    PADDR  = {16'h0, ADDR_PRESCALE};
                    PWDATA = {16'h0, PRESCALE};
                end
                S_INIT_CTRL: begin
                    PSEL   = 1'b1;
                    PWRITE = 1'b1;
                    PADDR  = {16'h0, ADDR_CTRL};
                    PWDATA = CTRL_VAL;
                end
                S_CLR: begin
                    PSEL   = 1'b1;
                    PWRITE = 1'b1;
                    PADDR  = {16'h0, ADDR_ICR};
                    PWDATA = 32'h1;
                end
                S_POLL: begin
                    PSEL   = 1'b1;
                    PADDR  = {16'h0, ADDR_RIS};
                end
                S_WR: begin
                    PSEL   = 1'b1;
                    PWRITE = 1'b1;
                    PADDR  = {16'h0, ADDR_DATA};
                    PWDATA = {24'h0, byte_q};
                    if (access_q && PREADY) begin
                        req_ready[grant_q] = 1'b1;
                    end
                end
                default: begin
                end
            endcase
            PENABLE = PSEL && access_q;
        end
    end

    assign init_done = init_done_q;

endmodule
